ext_int_gen: RTL and testbench

External interrupt source that drives the `interrupt` input of the `mips` top.
- Watches `macroscopic_pc` and raises `interrupt` when the PC reaches a programmed target.
- Holds `interrupt` until the CPU's exception handler writes the interrupt-acknowledge address (0x7F20) on the `m_int_*` bus.
- Enforces a gap, a fire limit and an optional acknowledge timeout.
- Replaces ad-hoc interrupt stimulus with a synthesizable, reusable block that benches and system tops instantiate beside `mips`.

---
 rtl/ext_int_gen_if.sv | 22 ++
 rtl/ext_int_gen.sv | 132 +++++++++++++
 tb/tb_ext_int_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_int_gen_if.sv
// CPU-side interrupt bus seen by ext_int_gen: PC and acknowledge-write
// signals go into the block, and the interrupt request comes back out.
interface ext_int_gen_if;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;

  modport master (
    output macroscopic_pc,
    output m_int_addr,
    output m_int_byteen,
    input  interrupt
  );

  modport slave (
    input  macroscopic_pc,
    input  m_int_addr,
    input  m_int_byteen,
    output interrupt
  );
endinterface

// File: rtl/ext_int_gen.sv
// External interrupt source: fires when the PC hits TARGET_PC, holds the request until an ACK_ADDR write,
// then observes a re-arm gap; one cycle from pc_hit to interrupt, no backpressure (the CPU acks at its own pace).
module ext_int_gen #(
  parameter logic [31:0] TARGET_PC  = 32'h0000_3010,
  parameter logic [31:0] ACK_ADDR   = 32'h0000_7f20,
  parameter logic [7:0]  MAX_FIRES  = 8'd1,
  parameter logic [7:0]  GAP_CYCLES = 8'd8,
  parameter logic [15:0] TIMEOUT    = 16'd0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  ext_int_gen_if.slave bus,
  output logic [7:0]   fire_count,
  output logic         busy,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hffff_fffc;

  state_e      state_q, state_d;
  logic        irq_q, irq_d;
  logic [7:0]  fire_q, fire_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] tmo_q, tmo_d;
  logic        armed_q, armed_d;
  logic        terr_q, terr_d;

  logic        pc_hit;
  logic        ack;
  logic        limit_ok;
  logic [7:0]  fire_inc;
  logic [15:0] tmo_inc;
  logic        tmo_expired;

  assign pc_hit = ((bus.macroscopic_pc & WORD_MASK) == (TARGET_PC & WORD_MASK));
  assign ack    = (|bus.m_int_byteen) &&
                  ((bus.m_int_addr & WORD_MASK) == (ACK_ADDR & WORD_MASK));

  // The same test gates new triggers in IDLE and picks DONE on leaving GAP.
  assign limit_ok = (MAX_FIRES == 8'd0) || (fire_q < MAX_FIRES);

  assign fire_inc    = (fire_q == 8'hff)    ? fire_q : fire_q + 8'd1;
  assign tmo_inc     = (tmo_q == 16'hffff)  ? tmo_q  : tmo_q + 16'd1;
  assign tmo_expired = (TIMEOUT != 16'd0) && (tmo_inc == TIMEOUT);

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    fire_d  = fire_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    terr_d  = terr_q;
    // Any cycle off the target re-arms, so a PC stalled on it fires once per visit.
    armed_d = pc_hit ? armed_q : 1'b1;

    unique case (state_q)
      IDLE: begin
        if (enable && pc_hit && armed_q && limit_ok) begin
          state_d = ASSERT;
          irq_d   = 1'b1;
          fire_d  = fire_inc;
          armed_d = 1'b0;
          tmo_d   = 16'd0;
        end
      end
      ASSERT: begin
        if (ack) begin
          state_d = GAP;
          irq_d   = 1'b0;
          gap_d   = GAP_CYCLES;
          tmo_d   = 16'd0;
        end else if (tmo_expired) begin
          state_d = GAP;
          irq_d   = 1'b0;
          gap_d   = GAP_CYCLES;
          tmo_d   = 16'd0;
          terr_d  = 1'b1;
        end else begin
          tmo_d   = tmo_inc;
        end
      end
      GAP: begin
        if (gap_q == 8'd0) begin
          state_d = limit_ok ? IDLE : DONE;
        end else begin
          gap_d   = gap_q - 8'd1;
        end
      end
      DONE: begin
        irq_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      fire_q  <= 8'd0;
      gap_q   <= 8'd0;
      tmo_q   <= 16'd0;
      armed_q <= 1'b1;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      fire_q  <= fire_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      armed_q <= armed_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.interrupt = irq_q;
  assign fire_count    = fire_q;
  assign busy          = (state_q == ASSERT) || (state_q == GAP);
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_ext_int_gen.sv
// Three ext_int_gen configurations share one random/directed stimulus stream; a behavioural model
// queues expected outputs per cycle and a separate monitor pops and compares them after each edge.
module tb_ext_int_gen;

  typedef logic [10:0] obs_t;  // {interrupt, fire_count[7:0], busy, timeout_err}

  logic clk;
  logic reset;
  logic enable;
  logic rst_drv;

  ext_int_gen_if b0();
  ext_int_gen_if b1();
  ext_int_gen_if b2();

  logic [7:0] fc0, fc1, fc2;
  logic       by0, by1, by2;
  logic       te0, te1, te2;

  ext_int_gen #(.MAX_FIRES(8'd1), .GAP_CYCLES(8'd8), .TIMEOUT(16'd0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .bus(b0),
    .fire_count(fc0), .busy(by0), .timeout_err(te0));
  ext_int_gen #(.MAX_FIRES(8'd0), .GAP_CYCLES(8'd2), .TIMEOUT(16'd0)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .bus(b1),
    .fire_count(fc1), .busy(by1), .timeout_err(te1));
  ext_int_gen #(.MAX_FIRES(8'd0), .GAP_CYCLES(8'd0), .TIMEOUT(16'd5)) u2 (
    .clk(clk), .reset(reset), .enable(enable), .bus(b2),
    .fire_count(fc2), .busy(by2), .timeout_err(te2));

  int n_cmp  = 0;
  int n_fail = 0;

  obs_t q0[$];
  obs_t q1[$];
  obs_t q2[$];

  // Behavioural model: one entry per instance.
  bit m_irq   [3];
  bit m_gap   [3];
  bit m_done  [3];
  bit m_armed [3];
  bit m_terr  [3];
  int m_fires [3];
  int m_high  [3];
  int m_gspent[3];

  function automatic int p_mf(int i);
    return (i == 0) ? 1 : 0;
  endfunction
  function automatic int p_gap(int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 0);
  endfunction
  function automatic int p_tmo(int i);
    return (i == 2) ? 5 : 0;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic obs_t act(int i);
    case (i)
      0:       return {b0.interrupt, fc0, by0, te0};
      1:       return {b1.interrupt, fc1, by1, te1};
      default: return {b2.interrupt, fc2, by2, te2};
    endcase
  endfunction

  function automatic obs_t model_obs(int i);
    obs_t o;
    o = {m_irq[i], 8'(m_fires[i]), (m_irq[i] | m_gap[i]), m_terr[i]};
    return o;
  endfunction

  task automatic model_reset(int i);
    m_irq[i] = 0; m_gap[i] = 0; m_done[i] = 0; m_armed[i] = 1;
    m_terr[i] = 0; m_fires[i] = 0; m_high[i] = 0; m_gspent[i] = 0;
  endtask

  task automatic model_step(int i, logic [31:0] pc, logic [31:0] addr, logic [3:0] be, logic en);
    bit hit, ackw, arm_next;
    hit      = (pc >> 2) == (32'h0000_3010 >> 2);
    ackw     = (be != 4'd0) && ((addr >> 2) == (32'h0000_7f20 >> 2));
    arm_next = hit ? m_armed[i] : 1'b1;
    if (m_done[i]) begin
      // dormant until reset
    end else if (m_irq[i]) begin
      if (ackw) begin
        m_irq[i] = 0; m_gap[i] = 1; m_gspent[i] = 0;
      end else if (p_tmo(i) != 0 && m_high[i] >= p_tmo(i)) begin
        m_irq[i] = 0; m_gap[i] = 1; m_gspent[i] = 0; m_terr[i] = 1;
      end else begin
        m_high[i]++;
      end
    end else if (m_gap[i]) begin
      m_gspent[i]++;
      if (m_gspent[i] == p_gap(i) + 1) begin
        m_gap[i]  = 0;
        m_done[i] = (p_mf(i) != 0) && (m_fires[i] >= p_mf(i));
      end
    end else if (en && hit && m_armed[i] && (p_mf(i) == 0 || m_fires[i] < p_mf(i))) begin
      m_irq[i]   = 1;
      m_high[i]  = 1;
      m_fires[i] = (m_fires[i] >= 255) ? 255 : m_fires[i] + 1;
      arm_next   = 0;
    end
    m_armed[i] = arm_next;
  endtask

  task automatic push_exp(int i, obs_t v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic compare(string name, int i, obs_t got, obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s u%0d t=%0t got irq=%b fc=%0d busy=%b terr=%b want irq=%b fc=%0d busy=%b terr=%b",
               name, i, $time, got[10], got[9:2], got[1], got[0],
               want[10], want[9:2], want[1], want[0]);
    end
  endtask

  // One stimulus cycle: drive at the falling edge, advance the model over the next rising edge.
  task automatic cyc(logic [31:0] pc, logic [31:0] addr, logic [3:0] be, logic en);
    @(negedge clk);
    reset  = rst_drv;
    enable = en;
    b0.macroscopic_pc = pc; b0.m_int_addr = addr; b0.m_int_byteen = be;
    b1.macroscopic_pc = pc; b1.m_int_addr = addr; b1.m_int_byteen = be;
    b2.macroscopic_pc = pc; b2.m_int_addr = addr; b2.m_int_byteen = be;
    for (int i = 0; i < 3; i++) begin
      if (!rst_drv) model_reset(i);
      else          model_step(i, pc, addr, be, en);
      push_exp(i, model_obs(i));
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cyc(32'h100, 32'h0, 4'h0, 1'b1);
  endtask

  // Reset asserted between edges: outputs must clear before the next rising edge.
  task automatic areset();
    #2;
    rst_drv = 1'b0;
    reset   = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      compare("async_rst", i, act(i), 11'd0);
      model_reset(i);
    end
    if (q0.size() > 0) void'(q0.pop_back());
    if (q1.size() > 0) void'(q1.pop_back());
    if (q2.size() > 0) void'(q2.pop_back());
    for (int i = 0; i < 3; i++) push_exp(i, model_obs(i));
  endtask

  task automatic sb_check(int i);
    obs_t e;
    bit   got;
    got = 0;
    case (i)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); got = 1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); got = 1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1; end
    endcase
    if (got) compare("sb", i, act(i), e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 3; i++) sb_check(i);
    end
  end

  initial begin
    logic [31:0] pc, addr;
    logic [3:0]  be;
    logic        en;
    int          r;

    rst_drv = 1'b1;
    reset   = 1'b1;
    enable  = 1'b0;
    b0.macroscopic_pc = 32'h0; b0.m_int_addr = 32'h0; b0.m_int_byteen = 4'h0;
    b1.macroscopic_pc = 32'h0; b1.m_int_addr = 32'h0; b1.m_int_byteen = 4'h0;
    b2.macroscopic_pc = 32'h0; b2.m_int_addr = 32'h0; b2.m_int_byteen = 4'h0;
    #1;
    reset   = 1'b0;
    rst_drv = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      model_reset(i);
      compare("reset", i, act(i), 11'd0);
    end
    idle(3);
    rst_drv = 1'b1;
    idle(2);

    // Basic fire, then ignored and accepted acknowledges.
    cyc(32'h3010, 32'h0, 4'h0, 1'b1);
    idle(2);
    cyc(32'h100, 32'h7f24, 4'hf, 1'b1);
    cyc(32'h100, 32'h7f20, 4'h0, 1'b1);
    cyc(32'h100, 32'h7f22, 4'b0100, 1'b1);
    idle(12);
    cyc(32'h3010, 32'h0, 4'h0, 1'b1);
    idle(3);
    cyc(32'h100, 32'h7f20, 4'b0001, 1'b1);
    idle(4);

    // Unaligned PC held through ack and gap, then leaves for one cycle and returns.
    for (int k = 0; k < 4; k++) cyc(32'h3013, 32'h0, 4'h0, 1'b1);
    cyc(32'h3013, 32'h7f20, 4'h1, 1'b1);
    for (int k = 0; k < 8; k++) cyc(32'h3011, 32'h0, 4'h0, 1'b1);
    cyc(32'h200, 32'h0, 4'h0, 1'b1);
    cyc(32'h3010, 32'h0, 4'h0, 1'b1);
    cyc(32'h3010, 32'h7f20, 4'h8, 1'b1);
    idle(6);

    // Enable gating and enable dropped while asserted.
    cyc(32'h3010, 32'h0, 4'h0, 1'b0);
    cyc(32'h3010, 32'h0, 4'h0, 1'b0);
    idle(2);
    cyc(32'h3010, 32'h0, 4'h0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(32'h3010, 32'h0, 4'h0, 1'b0);
    cyc(32'h100, 32'h7f20, 4'hf, 1'b0);
    idle(15);

    // Asynchronous reset in the middle of an asserted interrupt, then normal operation.
    cyc(32'h3010, 32'h0, 4'h0, 1'b1);
    cyc(32'h100, 32'h0, 4'h0, 1'b1);
    areset();
    idle(2);
    rst_drv = 1'b1;
    idle(2);

    // Ack lands on the same edge as the timeout: ack wins, no error flag.
    cyc(32'h3010, 32'h0, 4'h0, 1'b1);
    idle(4);
    cyc(32'h100, 32'h7f20, 4'h2, 1'b1);
    idle(10);

    // Randomized traffic with occasional mid-cycle resets.
    for (int k = 0; k < 1500; k++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      pc = 32'h3010 | 32'($urandom_range(0, 3));
      else if (r < 6) pc = 32'h100;
      else            pc = $urandom;
      r = $urandom_range(0, 9);
      if (r < 2)       begin addr = 32'h7f20 | 32'($urandom_range(0, 3)); be = 4'($urandom_range(1, 15)); end
      else if (r == 2) begin addr = 32'h7f20; be = 4'h0; end
      else if (r == 3) begin addr = 32'h7f24; be = 4'hf; end
      else             begin addr = $urandom; be = 4'h0; end
      en = ($urandom_range(0, 7) != 0);
      cyc(pc, addr, be, en);
      if ($urandom_range(0, 199) == 0) begin
        areset();
        idle(1);
        rst_drv = 1'b1;
      end
    end
    idle(2);
    @(posedge clk);
    #4;
    n_cmp++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got %0d entries left want 0", q0.size() + q1.size() + q2.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
